// File: rtl/encoder_dense_mac.sv
// encoder_dense_mac: sequential dense layer, one MAC per cycle, one neuron at a time.
// Rev 1.0 - initial release.
`default_nettype none

module encoder_dense_mac #(
  parameter int N_IN  = 8,
  parameter int N_OUT = 4,
  parameter int DIN_W = 16,
  parameter int W_W   = 6,
  parameter int ACC_W = 32,
  parameter int OUT_W = 16,
  parameter int SHIFT = 6,
  localparam int NW   = N_IN * N_OUT,
  localparam int AW   = (NW > 1) ? $clog2(NW) : 1
) (
  input  logic             ap_clk,
  input  logic             ap_rst,
  input  logic             w_we,
  input  logic [AW-1:0]    w_addr,
  input  logic [W_W-1:0]   w_data,
  input  logic [DIN_W-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy
);

  localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int JW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int PW = DIN_W + W_W;
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    MAC  = 2'd1,
    EMIT = 2'd2
  } state_t;

  state_t                  state;
  logic [IW-1:0]           cnt;
  logic [IW-1:0]           col;
  logic [JW-1:0]           row;
  logic signed [DIN_W-1:0] x [N_IN];
  logic [W_W-1:0]          w_mem [NW];
  logic signed [ACC_W-1:0] acc;
  logic [OUT_W-1:0]        out_q;

  logic [AW-1:0]           w_idx;
  logic signed [PW-1:0]    x_ext;
  logic signed [PW-1:0]    w_ext;
  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] acc_sum;
  logic signed [ACC_W-1:0] shifted;
  logic [OUT_W-1:0]        quant;
  logic                    addr_ok;
  logic                    w_write;

  // Both operands widened to the full product width first; the exact product fits.
  always_comb begin
    w_idx   = AW'(int'(row) * N_IN + int'(col));
    x_ext   = PW'(x[col]);
    w_ext   = PW'($signed({1'b0, w_mem[w_idx]}));
    prod    = x_ext * w_ext;
    acc_sum = acc + {{(ACC_W-PW){prod[PW-1]}}, prod};
    shifted = acc_sum >>> SHIFT;
    quant   = shifted[OUT_W-1:0];
    if (shifted > SAT_MAX)
      quant = SAT_MAX[OUT_W-1:0];
    else if (shifted < SAT_MIN)
      quant = SAT_MIN[OUT_W-1:0];
  end

  generate
    if (NW == (1 << AW)) begin : g_addr_full
      assign addr_ok = 1'b1;
    end else begin : g_addr_part
      assign addr_ok = (32'(w_addr) < 32'(NW));
    end
  endgenerate

  // Weights may only change while the engine is idle with an empty input buffer.
  assign w_write = w_we && addr_ok && (state == LOAD) && (cnt == '0);

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      for (int k = 0; k < NW; k++) w_mem[k] <= '0;
    end else if (w_write) begin
      w_mem[w_addr] <= w_data;
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state <= LOAD;
      cnt   <= '0;
      col   <= '0;
      row   <= '0;
      acc   <= '0;
      out_q <= '0;
      for (int k = 0; k < N_IN; k++) x[k] <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (in_valid) begin
            x[cnt] <= in_data;
            if (cnt == IW'(N_IN - 1)) begin
              cnt   <= '0;
              col   <= '0;
              row   <= '0;
              acc   <= '0;
              state <= MAC;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        MAC: begin
          acc <= acc_sum;
          if (col == IW'(N_IN - 1)) begin
            out_q <= quant;
            state <= EMIT;
          end else begin
            col <= col + 1'b1;
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (row == JW'(N_OUT - 1)) begin
              row   <= '0;
              cnt   <= '0;
              state <= LOAD;
            end else begin
              row   <= row + 1'b1;
              col   <= '0;
              acc   <= '0;
              state <= MAC;
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  assign in_ready  = (state == LOAD) && !ap_rst;
  assign out_valid = (state == EMIT);
  assign out_last  = (state == EMIT) && (row == JW'(N_OUT - 1));
  assign out_data  = out_q;
  assign busy      = !((state == LOAD) && (cnt == '0));

endmodule

`default_nettype wire

// File: tb/tb_encoder_dense_mac.sv
// tb_encoder_dense_mac: directed vectors with hand-computed latent outputs.
// Rev 1.0 - initial release.
`default_nettype none

module tb_encoder_dense_mac;

  logic        ap_clk = 1'b0;
  logic        ap_rst = 1'b0;
  logic        w_we = 1'b0;
  logic [4:0]  w_addr = '0;
  logic [5:0]  w_data = '0;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_last;
  logic        busy;

  int checks = 0;
  int failures = 0;

  encoder_dense_mac dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // mode 0: all ones, mode 1: neuron j gets j+1, mode 2: all 63
  task automatic load_weights(input int mode);
    for (int a = 0; a < 32; a++) begin
      w_we   = 1'b1;
      w_addr = 5'(a);
      w_data = (mode == 0) ? 6'd1 : (mode == 1) ? 6'(a / 8 + 1) : 6'd63;
      @(negedge ap_clk);
    end
    w_we = 1'b0;
  endtask

  // Returns at the negedge right after the last activation is accepted.
  task automatic send(input logic [15:0] v, input bit gaps);
    for (int k = 0; k < 8; k++) begin
      if (gaps) begin
        in_valid = 1'b0;
        in_data  = 16'h7FFF;
        @(negedge ap_clk);
      end
      check("in_ready_load", in_ready, 1);
      in_valid = 1'b1;
      in_data  = v;
      @(negedge ap_clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic collect(input int e0, input int e1, input int e2, input int e3, input bit chk_lat);
    int exp_v [4];
    int n;
    int lat;
    exp_v = '{e0, e1, e2, e3};
    n = 0;
    lat = -1;
    for (int cyc = 1; cyc <= 200 && n < 4; cyc++) begin
      if (out_valid && out_ready) begin
        if (lat < 0) lat = cyc;
        check("out_data", $signed(out_data), exp_v[n]);
        check("out_last", int'(out_last), int'(n == 3));
        n++;
      end
      if (n < 4) @(negedge ap_clk);
    end
    check("out_count", n, 4);
    // 8 MAC cycles separate the last accept from the first EMIT cycle.
    if (chk_lat) check("first_valid_latency", lat, 9);
    @(negedge ap_clk);
    check("in_ready_after", in_ready, 1);
    check("busy_after", busy, 0);
    check("out_valid_after", out_valid, 0);
  endtask

  initial begin
    ap_rst = 1'b1;
    repeat (2) @(negedge ap_clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    ap_rst = 1'b0;
    @(negedge ap_clk);
    check("rst_in_ready_rel", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_out_data", $signed(out_data), 0);
    check("rst_out_last", out_last, 0);

    load_weights(0);
    send(16'd64, 1'b0);
    collect(8, 8, 8, 8, 1'b1);

    load_weights(1);
    send(16'd64, 1'b0);
    collect(8, 16, 24, 32, 1'b1);

    load_weights(2);
    send(16'd32767, 1'b0);
    collect(32767, 32767, 32767, 32767, 1'b0);
    send(16'h8000, 1'b0);
    collect(-32768, -32768, -32768, -32768, 1'b0);

    // -504 >>> 6 floors to -8; hold the first result for 5 cycles
    out_ready = 1'b0;
    send(16'hFFFF, 1'b0);
    for (int c = 0; c < 40 && !out_valid; c++) @(negedge ap_clk);
    for (int c = 0; c < 5; c++) begin
      @(negedge ap_clk);
      check("bp_valid", out_valid, 1);
      check("bp_data", $signed(out_data), -8);
      check("bp_last", out_last, 0);
    end
    out_ready = 1'b1;
    collect(-8, -8, -8, -8, 1'b0);

    // 64*63*8 = 32256 -> 504; idle gaps carry junk data
    send(16'd64, 1'b1);
    collect(504, 504, 504, 504, 1'b0);

    send(16'd64, 1'b0);
    w_we = 1'b1; w_addr = 5'd0; w_data = 6'd5;
    @(negedge ap_clk);
    w_we = 1'b0;
    collect(504, 504, 504, 504, 1'b0);
    send(16'd64, 1'b0);
    collect(504, 504, 504, 504, 1'b0);

    // reset while neuron 2 is accumulating
    send(16'd64, 1'b0);
    repeat (19) @(negedge ap_clk);
    check("pre_rst_busy", busy, 1);
    check("pre_rst_valid", out_valid, 0);
    #2 ap_rst = 1'b1;
    #1;
    check("mid_rst_out_data", $signed(out_data), 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_out_last", out_last, 0);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    @(negedge ap_clk);
    check("post_rst_in_ready", in_ready, 1);
    send(16'd100, 1'b0);
    collect(0, 0, 0, 0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
